// File: rtl/raster_pkg.sv
// raster_pkg
//   Shared definitions for the rasterization front-end scheduler.
//   - ST_IDLE / ST_XFER : dispatch state encodings (legacy-compatible constants)
//   - VERTS_PER_TRI     : vertices transferred per grant
//   - grant_w()         : width of a requester index
//   - credit_w()        : width of the outstanding-triangle counter
package raster_pkg;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_XFER = 1'b1;

    localparam int VERTS_PER_TRI = 3;

    // Never narrower than one bit, so a degenerate configuration still elaborates.
    function automatic int grant_w(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

    // Must be able to hold the value max_inflight itself.
    function automatic int credit_w(input int max_inflight);
        return $clog2(max_inflight + 1);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
//   Combinational round-robin picker. The search starts one position after the
//   previous winner and wraps modulo NUM_REQ. The grant register lives in the
//   caller.
// Ports:
//   i_req        request vector
//   i_last_grant index of the previous winner
//   o_grant_oh   one-hot winner (all zero when nothing requests)
//   o_grant_idx  binary winner index
//   o_any        at least one request present
module rr_arbiter
    import raster_pkg::*;
#(
    parameter  int NUM_REQ = 2,
    localparam int GW      = grant_w(NUM_REQ)
)(
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [GW-1:0]      i_last_grant,
    output logic [NUM_REQ-1:0] o_grant_oh,
    output logic [GW-1:0]      o_grant_idx,
    output logic               o_any
);

    logic [GW-1:0] w_cand;

    always_comb begin
        o_grant_oh  = '0;
        o_grant_idx = '0;
        o_any       = 1'b0;
        w_cand      = '0;
        // k = NUM_REQ lands back on last_grant, so it is considered last.
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_cand = GW'((int'(i_last_grant) + k) % NUM_REQ);
            if (!o_any && i_req[w_cand]) begin
                o_any              = 1'b1;
                o_grant_idx        = w_cand;
                o_grant_oh[w_cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/raster_dispatch_ctrl.sv
// raster_dispatch_ctrl
//   Front-end scheduler for the rasterization pipeline. It arbitrates between
//   NUM_REQ vertex producers one triangle (three vertices) at a time. It
//   forwards the granted stream to primitive assembly and limits outstanding
//   triangles with a credit counter.
//
// Handshake: a vertex moves on every cycle where vtx_valid and vtx_ready are
//   both high. The granted requester sees req_ready = vtx_ready, so the pair
//   req_valid/req_ready is the same transfer seen from the producer side. The
//   vertex path is purely combinational.
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   req_valid/req_ready      per-requester vertex handshake
//   req_x/y/z/w              packed coordinates, requester i in slice i
//   vtx_valid/vtx_ready      vertex handshake to primitive assembly
//   vtx_x/y/z/w, vtx_src     forwarded vertex and its requester index
//   tri_done                 one pulse per retired triangle
//   start_pipeline, busy     transfer active or triangles outstanding
//   inflight                 outstanding triangle count
//   underflow_err            sticky: tri_done seen with nothing outstanding
//   timeout_err              sticky watchdog flag
//
// Build option: RASTER_DISPATCH_TIMEOUT_EN adds a watchdog. The watchdog
//   counts cycles without tri_done while triangles are outstanding. At
//   TIMEOUT_CYCLES it sets timeout_err and drops the credit count to zero.
//   Without the option timeout_err is tied low.
module raster_dispatch_ctrl
    import raster_pkg::*;
#(
    parameter  int COORD_W        = 32,
    parameter  int NUM_REQ        = 2,
    parameter  int MAX_INFLIGHT   = 4,
    parameter  int TIMEOUT_CYCLES = 4096,
    localparam int GW             = grant_w(NUM_REQ),
    localparam int CW             = credit_w(MAX_INFLIGHT)
)(
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*COORD_W-1:0] req_x,
    input  logic [NUM_REQ*COORD_W-1:0] req_y,
    input  logic [NUM_REQ*COORD_W-1:0] req_z,
    input  logic [NUM_REQ*COORD_W-1:0] req_w,
    output logic                       vtx_valid,
    input  logic                       vtx_ready,
    output logic [COORD_W-1:0]         vtx_x,
    output logic [COORD_W-1:0]         vtx_y,
    output logic [COORD_W-1:0]         vtx_z,
    output logic [COORD_W-1:0]         vtx_w,
    output logic [GW-1:0]              vtx_src,
    input  logic                       tri_done,
    output logic                       start_pipeline,
    output logic                       busy,
    output logic [CW-1:0]              inflight,
    output logic                       underflow_err,
    output logic                       timeout_err
);

    logic [0:0]         r_state;
    logic [GW-1:0]      r_grant;
    logic [GW-1:0]      r_last_grant;
    logic [1:0]         r_vcnt;
    logic [CW-1:0]      r_inflight;
    logic               r_underflow_err;

    logic [NUM_REQ-1:0] w_arb_oh_unused;
    logic [GW-1:0]      w_arb_idx;
    logic               w_arb_any;
    logic               w_grant_ok;
    logic               w_hs;
    logic               w_tri_hs;
    logic               w_wdog_fire;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .i_req        (req_valid),
        .i_last_grant (r_last_grant),
        .o_grant_oh   (w_arb_oh_unused),
        .o_grant_idx  (w_arb_idx),
        .o_any        (w_arb_any)
    );

    assign w_grant_ok = (r_state == ST_IDLE) && w_arb_any && (r_inflight < CW'(MAX_INFLIGHT));
    assign w_hs       = vtx_valid && vtx_ready;
    assign w_tri_hs   = w_hs && (r_vcnt == 2'(VERTS_PER_TRI - 1));

    // Datapath mux. The grant stays locked for the whole triangle; when the
    // granted producer drops valid, the transfer only stalls.
    always_comb begin
        vtx_valid = 1'b0;
        req_ready = '0;
        vtx_x     = '0;
        vtx_y     = '0;
        vtx_z     = '0;
        vtx_w     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_grant == GW'(i)) begin
                vtx_x = req_x[i*COORD_W +: COORD_W];
                vtx_y = req_y[i*COORD_W +: COORD_W];
                vtx_z = req_z[i*COORD_W +: COORD_W];
                vtx_w = req_w[i*COORD_W +: COORD_W];
                if (r_state == ST_XFER) begin
                    vtx_valid    = req_valid[i];
                    req_ready[i] = vtx_ready;
                end
            end
        end
    end

    assign vtx_src        = r_grant;
    assign busy           = (r_state == ST_XFER) || (r_inflight != '0);
    assign start_pipeline = busy;
    assign inflight       = r_inflight;
    assign underflow_err  = r_underflow_err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_grant      <= '0;
            r_last_grant <= GW'(NUM_REQ - 1);   // requester 0 wins first
            r_vcnt       <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_ok) begin
                        r_grant <= w_arb_idx;
                        r_vcnt  <= '0;
                        r_state <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (w_tri_hs) begin
                        r_last_grant <= r_grant;
                        r_vcnt       <= '0;
                        r_state      <= ST_IDLE;
                    end else if (w_hs) begin
                        r_vcnt <= r_vcnt + 2'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef RASTER_DISPATCH_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] r_wdog;
    logic          r_timeout_err;

    assign w_wdog_fire = (r_wdog == TW'(TIMEOUT_CYCLES));
    assign timeout_err = r_timeout_err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wdog        <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            if (tri_done || (r_inflight == '0) || w_wdog_fire) begin
                r_wdog <= '0;
            end else begin
                r_wdog <= r_wdog + 1'b1;
            end
            if (w_wdog_fire) begin
                r_timeout_err <= 1'b1;
            end
        end
    end
`else
    logic w_unused_timeout;

    assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
    assign w_wdog_fire      = 1'b0;
    assign timeout_err      = 1'b0;
`endif

    // Credit counter. A simultaneous grant completion and retirement cancel
    // out. A retirement with nothing outstanding is flagged and leaves the
    // count at zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_inflight      <= '0;
            r_underflow_err <= 1'b0;
        end else begin
            if (w_wdog_fire) begin
                r_inflight <= '0;
            end else if (w_tri_hs && !tri_done) begin
                r_inflight <= r_inflight + 1'b1;
            end else if (!w_tri_hs && tri_done && (r_inflight != '0)) begin
                r_inflight <= r_inflight - 1'b1;
            end
            if (tri_done && (r_inflight == '0)) begin
                r_underflow_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_raster_dispatch_ctrl.sv
module tb_raster_dispatch_ctrl;

    localparam int COORD_W = 32;
    localparam int VW      = 4 * COORD_W;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    req_valid;
    logic [1:0]    req_ready;
    logic [63:0]   req_x, req_y, req_z, req_w;
    logic          vtx_valid;
    logic          vtx_ready;
    logic [31:0]   vtx_x, vtx_y, vtx_z, vtx_w;
    logic [0:0]    vtx_src;
    logic          tri_done;
    logic          start_pipeline;
    logic          busy;
    logic [2:0]    inflight;
    logic          underflow_err;
    logic          timeout_err;

    raster_dispatch_ctrl #(
        .COORD_W(32), .NUM_REQ(2), .MAX_INFLIGHT(4), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_x(req_x), .req_y(req_y), .req_z(req_z), .req_w(req_w),
        .vtx_valid(vtx_valid), .vtx_ready(vtx_ready),
        .vtx_x(vtx_x), .vtx_y(vtx_y), .vtx_z(vtx_z), .vtx_w(vtx_w),
        .vtx_src(vtx_src), .tri_done(tri_done),
        .start_pipeline(start_pipeline), .busy(busy), .inflight(inflight),
        .underflow_err(underflow_err), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Producer model: each requester presents the head of its vertex queue.
    logic [VW-1:0]  q0[$];
    logic [VW-1:0]  q1[$];
    logic           en0, en1;
    // Scoreboard: {src, x, y, z, w} in the order primitive assembly must see them.
    logic [VW:0]    exp_q[$];

    int n_vec = 0;
    int n_err = 0;
    int m_inflight = 0;     // reference credit count
    int m_hs = 0;           // vertices of the current triangle seen so far
    int m_seen = 0;         // total vertices matched by the scoreboard
    int m_last = 1;         // reference round-robin pointer
    bit chk_inflight = 1'b1;
    bit stall_pending = 1'b0;
    logic [VW:0] stall_snap;

    function automatic int rr_next(input logic [1:0] mask, input int last);
        for (int k = 1; k <= 2; k++) begin
            if (mask[(last + k) % 2]) return (last + k) % 2;
        end
        return -1;
    endfunction

    task automatic drive();
        logic [VW-1:0] v0, v1;
        v0 = (q0.size() != 0) ? q0[0] : '0;
        v1 = (q1.size() != 0) ? q1[0] : '0;
        req_valid = {en1 && (q1.size() != 0), en0 && (q0.size() != 0)};
        req_x = {v1[127:96], v0[127:96]};
        req_y = {v1[95:64],  v0[95:64]};
        req_z = {v1[63:32],  v0[63:32]};
        req_w = {v1[31:0],   v0[31:0]};
    endtask

    task automatic push_tri(input int src, output logic [3*VW-1:0] t);
        logic [VW-1:0] v;
        for (int i = 0; i < 3; i++) begin
            v = {$urandom, $urandom, $urandom, $urandom};
            t[3*VW-1-VW*i -: VW] = v;
            if (src == 0) q0.push_back(v); else q1.push_back(v);
        end
    endtask

    task automatic exp_tri(input int src, input logic [3*VW-1:0] t);
        for (int i = 0; i < 3; i++) exp_q.push_back({1'(src), t[3*VW-1-VW*i -: VW]});
    endtask

    // One clock: sample mid-cycle, advance past the edge, update the model.
    task automatic tick();
        logic h0, h1, vh, dn, tri_cmp;
        logic [VW:0] obs;
        #1;
        h0 = req_valid[0] & req_ready[0];
        h1 = req_valid[1] & req_ready[1];
        vh = vtx_valid & vtx_ready;
        dn = tri_done;
        tri_cmp = 1'b0;
        obs = {vtx_src, vtx_x, vtx_y, vtx_z, vtx_w};
        n_vec++;
        if ((h0 | h1) !== vh) begin
            n_err++;
            $display("FAIL hs_consistency: req hs %b%b vtx hs %b", h1, h0, vh);
        end
        if (stall_pending) begin
            n_vec++;
            if (obs !== stall_snap) begin
                n_err++;
                $display("FAIL stall_stable: got %h want %h", obs, stall_snap);
            end
        end
        if (vh) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL sb_unexpected: got %h want none", obs);
            end else begin
                if (obs !== exp_q[0]) begin
                    n_err++;
                    $display("FAIL sb_vertex: got %h want %h", obs, exp_q[0]);
                end
                void'(exp_q.pop_front());
            end
            m_seen++;
            m_hs++;
            if (m_hs == 3) begin
                m_hs = 0;
                tri_cmp = 1'b1;
            end
        end
        stall_pending = vtx_valid && !vtx_ready;
        stall_snap = obs;
        @(posedge clk);
        #1;
        if (h0) void'(q0.pop_front());
        if (h1) void'(q1.pop_front());
        if (tri_cmp && !dn) m_inflight++;
        else if (dn && !tri_cmp && m_inflight > 0) m_inflight--;
        tri_done = 1'b0;
        drive();
        #1;
        if (chk_inflight) begin
            n_vec++;
            if (inflight !== 3'(m_inflight)) begin
                n_err++;
                $display("FAIL inflight: got %0d want %0d", inflight, m_inflight);
            end
        end
    endtask

    task automatic retire(input int n);
        repeat (n) begin
            tri_done = 1'b1;
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        en0 = 1'b0;
        en1 = 1'b0;
        vtx_ready = 1'b0;
        tri_done = 1'b0;
        drive();
        repeat (3) @(posedge clk);
        #2;
        n_vec++;
        if ({vtx_valid, req_ready, start_pipeline, busy, inflight, underflow_err, timeout_err, vtx_src} !== 10'b0) begin
            n_err++;
            $display("FAIL reset_outputs: got %b want 0",
                     {vtx_valid, req_ready, start_pipeline, busy, inflight, underflow_err, timeout_err, vtx_src});
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        drive();
        #1;
        m_last = 1;
    endtask

    task automatic test_single();
        logic [3*VW-1:0] t;
        push_tri(0, t);
        exp_tri(0, t);
        en0 = 1'b1;
        vtx_ready = 1'b1;
        drive();
        #1;
        n_vec++;
        if ({vtx_valid, busy} !== 2'b00) begin
            n_err++;
            $display("FAIL single_latency: got valid/busy %b want 00", {vtx_valid, busy});
        end
        tick();
        n_vec++;
        if ({vtx_valid, vtx_src, req_ready} !== 4'b1001) begin
            n_err++;
            $display("FAIL single_grant: got %b want 1001", {vtx_valid, vtx_src, req_ready});
        end
        repeat (3) tick();
        n_vec++;
        if ({start_pipeline, busy, vtx_valid} !== 3'b110 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL single_done: got %b left %0d want 110 left 0",
                     {start_pipeline, busy, vtx_valid}, exp_q.size());
        end
        m_last = 0;
        retire(1);
        n_vec++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL single_idle: got busy %b want 0", busy);
        end
    endtask

    task automatic test_contention();
        logic [3*VW-1:0] a[2];
        logic [3*VW-1:0] b[2];
        int c0, c1, g;
        for (int i = 0; i < 2; i++) begin
            push_tri(0, a[i]);
            push_tri(1, b[i]);
        end
        c0 = 0;
        c1 = 0;
        for (int i = 0; i < 4; i++) begin
            g = rr_next({c1 < 2, c0 < 2}, m_last);
            if (g == 0) begin exp_tri(0, a[c0]); c0++; end
            else        begin exp_tri(1, b[c1]); c1++; end
            m_last = g;
        end
        en0 = 1'b1;
        en1 = 1'b1;
        vtx_ready = 1'b1;
        drive();
        #1;
        for (int t = 0; t < 16; t++) begin
            n_vec++;
            if (vtx_valid !== (t % 4 != 0)) begin
                n_err++;
                $display("FAIL contention_bubble cycle %0d: got %b want %b", t, vtx_valid, (t % 4 != 0));
            end
            tick();
        end
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL contention_drain: got %0d left want 0", exp_q.size());
        end
        retire(4);
    endtask

    task automatic test_back_to_back();
        logic [3*VW-1:0] t0, t1;
        int base;
        push_tri(0, t0);
        exp_tri(0, t0);
        en0 = 1'b1;
        en1 = 1'b1;
        vtx_ready = 1'b0;
        drive();
        tick();
        base = m_seen;
        for (int c = 0; c < 40 && exp_q.size() != 0; c++) begin
            vtx_ready = (c % 2 == 1);
            if (c == 2) begin
                push_tri(1, t1);
                exp_tri(1, t1);
            end
            en0 = !(c == 5 || c == 6);
            drive();
            #1;
            if (m_seen - base < 3) begin
                n_vec++;
                if (vtx_src !== 1'b0 || req_ready[1] !== 1'b0) begin
                    n_err++;
                    $display("FAIL bp_locked cycle %0d: got src %b ready1 %b want 0 0", c, vtx_src, req_ready[1]);
                end
            end
            tick();
        end
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL bp_timeout: got %0d left want 0", exp_q.size());
        end
        m_last = 1;
        vtx_ready = 1'b1;
        retire(2);
    endtask

    task automatic test_credit();
        logic [3*VW-1:0] t;
        for (int i = 0; i < 5; i++) begin
            push_tri(0, t);
            exp_tri(0, t);
        end
        en0 = 1'b1;
        en1 = 1'b0;
        vtx_ready = 1'b1;
        drive();
        repeat (16) tick();
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if (vtx_valid !== 1'b0 || inflight !== 3'd4) begin
                n_err++;
                $display("FAIL credit_block: got valid %b inflight %0d want 0 4", vtx_valid, inflight);
            end
            tick();
        end
        retire(1);
        n_vec++;
        if (vtx_valid !== 1'b0) begin
            n_err++;
            $display("FAIL credit_decide: got %b want 0", vtx_valid);
        end
        tick();
        n_vec++;
        if (vtx_valid !== 1'b1) begin
            n_err++;
            $display("FAIL credit_regrant: got %b want 1", vtx_valid);
        end
        tick();
        tick();
        tri_done = 1'b1;
        tick();
        n_vec++;
        if (inflight !== 3'd3 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL credit_coincide: got %0d left %0d want 3 left 0", inflight, exp_q.size());
        end
        m_last = 0;
        retire(3);
    endtask

    task automatic test_underflow();
        retire(1);
        n_vec++;
        if (underflow_err !== 1'b1 || inflight !== 3'd0) begin
            n_err++;
            $display("FAIL underflow_set: got err %b inflight %0d want 1 0", underflow_err, inflight);
        end
        tick();
        n_vec++;
        if (underflow_err !== 1'b1) begin
            n_err++;
            $display("FAIL underflow_sticky: got %b want 1", underflow_err);
        end
    endtask

    task automatic test_reset_mid();
        logic [3*VW-1:0] t;
        push_tri(0, t);
        exp_tri(0, t);
        en0 = 1'b1;
        vtx_ready = 1'b1;
        drive();
        repeat (3) tick();
        rst = 1'b0;
        #1;
        n_vec++;
        if ({vtx_valid, req_ready, busy, inflight, underflow_err} !== 8'b0) begin
            n_err++;
            $display("FAIL reset_mid: got %b want 0", {vtx_valid, req_ready, busy, inflight, underflow_err});
        end
        q0.delete();
        exp_q.delete();
        m_hs = 0;
        m_inflight = 0;
        m_last = 1;
        stall_pending = 1'b0;
        drive();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        push_tri(0, t);
        exp_tri(0, t);
        drive();
        #1;
        tick();
        n_vec++;
        if ({vtx_valid, vtx_src} !== 2'b10) begin
            n_err++;
            $display("FAIL reset_regrant: got %b want 10", {vtx_valid, vtx_src});
        end
        repeat (3) tick();
        m_last = 0;
    endtask

    task automatic test_timeout();
`ifdef RASTER_DISPATCH_TIMEOUT_EN
        repeat (16) tick();
        n_vec++;
        if (timeout_err !== 1'b0 || inflight !== 3'd1) begin
            n_err++;
            $display("FAIL timeout_early: got err %b inflight %0d want 0 1", timeout_err, inflight);
        end
        chk_inflight = 1'b0;
        tick();
        n_vec++;
        if (timeout_err !== 1'b1 || inflight !== 3'd0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL timeout_fire: got err %b inflight %0d busy %b want 1 0 0", timeout_err, inflight, busy);
        end
        m_inflight = 0;
        chk_inflight = 1'b1;
`else
        repeat (20) tick();
        n_vec++;
        if (timeout_err !== 1'b0 || inflight !== 3'd1) begin
            n_err++;
            $display("FAIL timeout_off: got err %b inflight %0d want 0 1", timeout_err, inflight);
        end
        retire(1);
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish want finish");
        $fatal(1, "bench stuck");
    end

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_back_to_back();
        test_credit();
        test_underflow();
        test_reset_mid();
        test_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
